// File: rtl/ram_sp_bytewr_if.sv
// rtl/ram_sp_bytewr_if.sv - access bus for ram_sp_bytewr
// RAM_PARITY_EN adds the par_err response signal.
interface ram_sp_bytewr_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic                  en;
   logic                  w;
   logic                  r;
   logic [ADDR_W-1:0]     add;
   logic [DATA_W/8-1:0]   be;
   logic [DATA_W-1:0]     d_in;
   logic [DATA_W-1:0]     d_out;
   logic                  rvalid;
   logic                  busy;
   logic                  addr_err;
`ifdef RAM_PARITY_EN
   logic                  par_err;

   modport master (
      output en, w, r, add, be, d_in,
      input  d_out, rvalid, busy, addr_err, par_err
   );
   modport slave (
      input  en, w, r, add, be, d_in,
      output d_out, rvalid, busy, addr_err, par_err
   );
`else
   modport master (
      output en, w, r, add, be, d_in,
      input  d_out, rvalid, busy, addr_err
   );
   modport slave (
      input  en, w, r, add, be, d_in,
      output d_out, rvalid, busy, addr_err
   );
`endif
endinterface

// File: rtl/ram_sp_bytewr.sv
// rtl/ram_sp_bytewr.sv - single-port RAM with byte-lane writes, registered read and clear sweep
// Optional RAM_PARITY_EN: per-word even parity bit and par_err strobe on reads.
module ram_sp_bytewr #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic clk,
   input  logic rst_n,
   ram_sp_bytewr_if.slave bus
);
   localparam int NB = DATA_W / 8;
`ifdef RAM_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   d_out_q, d_out_d;
   logic                rvalid_q, rvalid_d;
   logic                addr_err_q, addr_err_d;
`ifdef RAM_PARITY_EN
   logic                par_err_q, par_err_d;
`endif

   logic [MW-1:0]       mem_q [DEPTH];
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [MW-1:0]       wr_word;
   logic [MW-1:0]       rd_word;
   logic [DATA_W-1:0]   merged;
   logic                in_range;

   // Full-width compare so addresses past DEPTH never alias onto real words.
   assign in_range = ({1'b0, bus.add} < DEPTH_EXT);
   assign rd_word  = mem_q[bus.add];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         d_out_q    <= '0;
         rvalid_q   <= 1'b0;
         addr_err_q <= 1'b0;
`ifdef RAM_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         d_out_q    <= d_out_d;
         rvalid_q   <= rvalid_d;
         addr_err_q <= addr_err_d;
`ifdef RAM_PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[wr_addr] <= wr_word;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == LAST_PTR) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      end
   end

   always_comb begin
      d_out_d    = d_out_q;
      rvalid_d   = 1'b0;
      addr_err_d = 1'b0;
`ifdef RAM_PARITY_EN
      par_err_d  = 1'b0;
`endif
      wr_en      = 1'b0;
      wr_addr    = ptr_q;
      wr_word    = '0;
      merged     = rd_word[DATA_W-1:0];
      for (int i = 0; i < NB; i++) begin
         if (bus.be[i]) merged[8*i +: 8] = bus.d_in[8*i +: 8];
      end

      if (state_q == ST_CLEAR) begin
         wr_en = 1'b1;
      end else if (bus.en && (bus.r || bus.w)) begin
         if (!in_range) begin
            addr_err_d = 1'b1;
            if (bus.r) begin
               d_out_d  = '0;
               rvalid_d = 1'b1;
            end
         end else begin
            // Read samples the pre-write word, giving read-first behaviour.
            if (bus.r) begin
               d_out_d  = rd_word[DATA_W-1:0];
               rvalid_d = 1'b1;
`ifdef RAM_PARITY_EN
               par_err_d = ^rd_word;
`endif
            end
            if (bus.w) begin
               wr_en   = 1'b1;
               wr_addr = bus.add;
               wr_word[DATA_W-1:0] = merged;
`ifdef RAM_PARITY_EN
               wr_word[DATA_W] = ^merged;
`endif
            end
         end
      end
   end

   assign bus.d_out    = d_out_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.addr_err = addr_err_q;
   assign bus.busy     = (state_q == ST_CLEAR);
`ifdef RAM_PARITY_EN
   assign bus.par_err  = par_err_q;
`endif
endmodule

// File: tb/tb_ram_sp_bytewr.sv
// tb/tb_ram_sp_bytewr.sv - scoreboard bench for ram_sp_bytewr (DEPTH=8 and DEPTH=6 instances)
module tb_ram_sp_bytewr;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_sp_bytewr_if #(.DATA_W(16), .ADDR_W(3)) if8 ();
   ram_sp_bytewr_if #(.DATA_W(16), .ADDR_W(3)) if6 ();

   ram_sp_bytewr #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8.slave));
   ram_sp_bytewr #(.DATA_W(16), .ADDR_W(3), .DEPTH(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .bus(if6.slave));

   int nchk = 0;
   int nerr = 0;
   logic [16:0] q8[$];
   logic [16:0] q6[$];
   logic [16:0] e8, e6;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected read response is {addr_err, d_out}.
   always @(negedge clk) begin
      if (if8.rvalid === 1'b1) begin
         if (q8.size() == 0) chk("rvalid8_unexpected", 32'd1, 32'd0);
         else begin
            e8 = q8.pop_front();
            chk("d_out8", 32'(if8.d_out), 32'(e8[15:0]));
            chk("addr_err8", 32'(if8.addr_err), 32'(e8[16]));
         end
      end
      if (if6.rvalid === 1'b1) begin
         if (q6.size() == 0) chk("rvalid6_unexpected", 32'd1, 32'd0);
         else begin
            e6 = q6.pop_front();
            chk("d_out6", 32'(if6.d_out), 32'(e6[15:0]));
            chk("addr_err6", 32'(if6.addr_err), 32'(e6[16]));
         end
      end
   end

   task automatic op8(input logic e, input logic wr, input logic rd, input logic [2:0] a,
                      input logic [1:0] b, input logic [15:0] di, input logic [15:0] exp_d,
                      input logic exp_ae);
      if8.en = e; if8.w = wr; if8.r = rd; if8.add = a; if8.be = b; if8.d_in = di;
      if (e && rd) q8.push_back({exp_ae, exp_d});
      @(negedge clk);
   endtask

   task automatic op6(input logic e, input logic wr, input logic rd, input logic [2:0] a,
                      input logic [1:0] b, input logic [15:0] di, input logic [15:0] exp_d,
                      input logic exp_ae);
      if6.en = e; if6.w = wr; if6.r = rd; if6.add = a; if6.be = b; if6.d_in = di;
      if (e && rd) q6.push_back({exp_ae, exp_d});
      @(negedge clk);
   endtask

   task automatic wr8(input logic [2:0] a, input logic [1:0] b, input logic [15:0] di);
      op8(1'b1, 1'b1, 1'b0, a, b, di, 16'h0, 1'b0);
   endtask

   task automatic rd8(input logic [2:0] a, input logic [15:0] exp_d);
      op8(1'b1, 1'b0, 1'b1, a, 2'b00, 16'h0, exp_d, 1'b0);
   endtask

   task automatic count_busy(input string name);
      int n8 = 0;
      int n6 = 0;
      for (int i = 0; i < 20; i++) begin
         if (!if8.busy && !if6.busy) break;
         if (if8.busy) n8++;
         if (if6.busy) n6++;
         @(negedge clk);
      end
      chk({name, "_busy8"}, 32'(n8), 32'd8);
      chk({name, "_busy6"}, 32'(n6), 32'd6);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      if8.en = 0; if8.w = 0; if8.r = 0; if8.add = 0; if8.be = 0; if8.d_in = 0;
      if6.en = 0; if6.w = 0; if6.r = 0; if6.add = 0; if6.be = 0; if6.d_in = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(if8.busy), 32'd1);
      chk("rst_rvalid", 32'(if8.rvalid), 32'd0);
      chk("rst_addr_err", 32'(if8.addr_err), 32'd0);
      chk("rst_d_out", 32'(if8.d_out), 32'd0);

      rst_n = 1'b1;
      count_busy("sweep");
      for (int i = 0; i < 8; i++) rd8(3'(i), 16'h0000);

      for (int i = 0; i < 8; i++) wr8(3'(i), 2'b11, 16'(i + 1));
      for (int i = 0; i < 8; i++) rd8(3'(i), 16'(i + 1));

      wr8(3'd3, 2'b11, 16'hAAAA);
      wr8(3'd3, 2'b01, 16'h5555);
      rd8(3'd3, 16'hAA55);

      op8(1'b1, 1'b1, 1'b1, 3'd5, 2'b11, 16'd9, 16'd6, 1'b0);
      rd8(3'd5, 16'd9);

      op8(1'b0, 1'b1, 1'b0, 3'd4, 2'b11, 16'd10, 16'h0, 1'b0);
      chk("en0_rvalid", 32'(if8.rvalid), 32'd0);
      chk("en0_addr_err", 32'(if8.addr_err), 32'd0);
      rd8(3'd4, 16'd5);

      wr8(3'd2, 2'b00, 16'hFFFF);
      rd8(3'd2, 16'd3);
      op8(1'b1, 1'b0, 1'b0, 3'd1, 2'b11, 16'hFFFF, 16'h0, 1'b0);
      chk("nop_rvalid", 32'(if8.rvalid), 32'd0);
      op8(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 16'h0, 1'b0);

      op6(1'b1, 1'b1, 1'b0, 3'd5, 2'b11, 16'h1234, 16'h0, 1'b0);
      op6(1'b1, 1'b0, 1'b1, 3'd5, 2'b00, 16'h0, 16'h1234, 1'b0);
      op6(1'b1, 1'b0, 1'b1, 3'd7, 2'b00, 16'h0, 16'h0000, 1'b1);
      op6(1'b1, 1'b1, 1'b0, 3'd6, 2'b11, 16'hBEEF, 16'h0, 1'b0);
      chk("oor_wr_addr_err6", 32'(if6.addr_err), 32'd1);
      chk("oor_wr_rvalid6", 32'(if6.rvalid), 32'd0);
      op6(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 16'h0, 1'b0);
      chk("addr_err6_strobe", 32'(if6.addr_err), 32'd0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // Accesses issued during the sweep must be ignored.
      if8.en = 1; if8.w = 1; if8.r = 1; if8.add = 3'd0; if8.be = 2'b11; if8.d_in = 16'hFFFF;
      repeat (4) @(negedge clk);
      chk("mid_sweep_busy", 32'(if8.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      count_busy("resweep");
      rd8(3'd0, 16'h0000);
      rd8(3'd3, 16'h0000);
      rd8(3'd5, 16'h0000);
      op8(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 16'h0, 1'b0);
      op8(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 16'h0, 1'b0);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q6_drained", 32'(q6.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
